// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value,
// controller state encoding and the bitwise helper functions used by
// both the round datapath and the message-schedule update.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Round constants; K[0] is the leftmost word so K[t] indexes naturally.
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value; H0 word 0 sits in the top 32 bits, matching the
  // digest layout so the chain register can be loaded directly.
  localparam logic [255:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    Sigma0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    Sigma1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] choice(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z);
    choice = (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] majority(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] z);
    majority = (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// Purely combinational single SHA-256 compression round. The working
// registers travel as one 256-bit bundle with a in the top word and h in
// the bottom word; all sums wrap modulo 2^32.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] state_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_in;

  assign t1 = h + Sigma1(e) + choice(e, f, g) + k + w;
  assign t2 = Sigma0(a) + majority(a, b, c);

  // New a and e absorb the round sums; everything else shifts one place.
  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_iter_ctrl.sv
// Iterative SHA-256 compression controller: accepts one padded block at a
// time, runs 64 rounds through a single shared round instance, folds the
// result into the chaining value and hands out the final digest.
module sha256_iter_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy
);

  state_t state, next_state;

  logic [5:0]        t;
  logic [15:0][31:0] window;
  logic [255:0]      work;
  logic [255:0]      chain;
  logic [255:0]      round_out;
  logic [255:0]      feed_sum;
  logic [31:0]       new_word;
  logic              last_latched;
  logic              accept;

  sha256_round u_round (
    .state_in  (work),
    .k         (K[t]),
    .w         (window[0]),
    .state_out (round_out)
  );

  // Next schedule word, computed from the current 16-word window.
  assign new_word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

  // Per-word feed-forward of the working registers into the chain.
  always_comb begin
    feed_sum = '0;
    for (int i = 0; i < 8; i++) begin
      feed_sum[32*i +: 32] = chain[32*i +: 32] + work[32*i +: 32];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and state-decoded handshake outputs (no input-to-output paths
  // except through the accept qualifier, which only feeds registers).
  always_comb begin
    next_state = state;
    blk_ready  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        accept    = blk_valid;
        if (blk_valid) begin
          next_state = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (t == 6'd63) begin
          next_state = FEED;
        end
      end
      FEED: begin
        busy       = 1'b1;
        next_state = last_latched ? DONE : IDLE;
      end
      DONE: begin
        if (digest_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Block intake, round iteration and schedule update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t            <= '0;
      window       <= '0;
      work         <= '0;
      last_latched <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) begin
              window[i] <= blk_data[511 - 32*i -: 32];
            end
            work         <= blk_first ? H0 : chain;
            last_latched <= blk_last;
            t            <= '0;
          end
        end
        ROUND: begin
          work   <= round_out;
          window <= {new_word, window[15:1]};
          t      <= t + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Chaining value: reloaded on a first block, advanced at FEED, and
  // returned to H0 once a digest has been handed over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= H0;
    end else begin
      case (state)
        IDLE:    if (accept && blk_first) chain <= H0;
        FEED:    chain <= feed_sum;
        DONE:    if (digest_ready) chain <= H0;
        default: ;
      endcase
    end
  end

  // Registered digest output; it keeps its value after the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      if (state == FEED && last_latched) begin
        digest       <= feed_sum;
        digest_valid <= 1'b1;
      end else if (state == DONE && digest_ready) begin
        digest_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_iter_ctrl.sv
// Directed testbench for sha256_iter_ctrl using known SHA-256 test vectors.
module tb_sha256_iter_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [255:0] digest;
  logic         busy;

  int applied = 0;
  int miscompares = 0;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO_1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO_2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic [255:0] expected;
  } vec_t;

  vec_t vecs[3];

  sha256_iter_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_first    (blk_first),
    .blk_last     (blk_last),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .digest       (digest),
    .busy         (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a block until accepted; waits = cycles spent before the accept edge.
  task automatic apply_stimulus(input logic [511:0] d, input logic f, input logic l,
                                output int waits);
    blk_data  = d;
    blk_first = f;
    blk_last  = l;
    blk_valid = 1'b1;
    waits = 0;
    while (!blk_ready && waits < 300) begin
      tick();
      waits++;
    end
    if (!blk_ready) begin
      check_output("accept_timeout", 256'(blk_ready), 256'd1);
    end else begin
      tick();
    end
    blk_valid = 1'b0;
  endtask

  task automatic wait_digest(output int cycles);
    cycles = 0;
    while (!digest_valid && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  task automatic take_digest();
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
  endtask

  initial begin
    int w;
    int lat;
    int ready_seen;
    int busy_seen;
    int unstable;

    tick();
    tick();
    reset = 1'b0;

    check_output("reset_blk_ready", 256'(blk_ready), 256'd1);
    check_output("reset_digest_valid", 256'(digest_valid), 256'd0);
    check_output("reset_digest", digest, 256'd0);
    check_output("reset_busy", 256'(busy), 256'd0);

    // Third entry uses first=0 right after a completed message.
    vecs[0] = '{BLK_ABC,   1'b1, 1'b1, DIG_ABC};
    vecs[1] = '{BLK_EMPTY, 1'b1, 1'b1, DIG_EMPTY};
    vecs[2] = '{BLK_ABC,   1'b0, 1'b1, DIG_ABC};

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(vecs[i].data, vecs[i].first, vecs[i].last, w);
      check_output($sformatf("vec%0d_busy", i), 256'(busy), 256'd1);
      wait_digest(lat);
      check_output($sformatf("vec%0d_latency", i), 256'(lat), 256'd65);
      check_output($sformatf("vec%0d_digest", i), digest, vecs[i].expected);
      take_digest();
      check_output($sformatf("vec%0d_valid_clr", i), 256'(digest_valid), 256'd0);
      check_output($sformatf("vec%0d_ready_after", i), 256'(blk_ready), 256'd1);
      check_output($sformatf("vec%0d_digest_hold", i), digest, vecs[i].expected);
    end

    // Two-block message, second block held valid from right after the first.
    apply_stimulus(BLK_TWO_1, 1'b1, 1'b0, w);
    apply_stimulus(BLK_TWO_2, 1'b0, 1'b1, w);
    check_output("two_blk2_wait", 256'(w), 256'd65);
    wait_digest(lat);
    check_output("two_total_latency", 256'(w + 1 + lat), 256'd131);
    check_output("two_digest", digest, DIG_TWO);
    take_digest();

    // Backpressure: digest held, blk_valid pulsed, nothing accepted.
    apply_stimulus(BLK_ABC, 1'b1, 1'b1, w);
    wait_digest(lat);
    check_output("bp_latency", 256'(lat), 256'd65);
    ready_seen = 0;
    busy_seen = 0;
    unstable = 0;
    blk_data = BLK_EMPTY;
    blk_first = 1'b1;
    blk_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      blk_valid = (i % 2 == 0);
      tick();
      if (blk_ready) ready_seen++;
      if (busy) busy_seen++;
      if (digest !== DIG_ABC || digest_valid !== 1'b1) unstable++;
    end
    blk_valid = 1'b0;
    check_output("bp_ready_seen", 256'(ready_seen), 256'd0);
    check_output("bp_busy_seen", 256'(busy_seen), 256'd0);
    check_output("bp_unstable", 256'(unstable), 256'd0);
    take_digest();
    check_output("bp_ready_after", 256'(blk_ready), 256'd1);
    check_output("bp_busy_after", 256'(busy), 256'd0);

    // Reset during round 30, then a fresh "abc".
    apply_stimulus(BLK_ABC, 1'b1, 1'b1, w);
    repeat (30) tick();
    check_output("rst_busy_before", 256'(busy), 256'd1);
    reset = 1'b1;
    #1;
    check_output("rst_blk_ready", 256'(blk_ready), 256'd1);
    check_output("rst_busy", 256'(busy), 256'd0);
    check_output("rst_digest_valid", 256'(digest_valid), 256'd0);
    check_output("rst_digest", digest, 256'd0);
    tick();
    reset = 1'b0;
    apply_stimulus(BLK_ABC, 1'b1, 1'b1, w);
    wait_digest(lat);
    check_output("rst_abc_latency", 256'(lat), 256'd65);
    check_output("rst_abc_digest", digest, DIG_ABC);
    take_digest();

    // Abandoned message: first block of two-block message, then fresh "abc".
    apply_stimulus(BLK_TWO_1, 1'b1, 1'b0, w);
    apply_stimulus(BLK_ABC, 1'b1, 1'b1, w);
    check_output("abandon_wait", 256'(w), 256'd65);
    wait_digest(lat);
    check_output("abandon_digest", digest, DIG_ABC);
    take_digest();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
